// File: rtl/clk_div_scheduler_if.sv
// Control and status bundle of the divided-clock scheduler.
// The master is the system controller; the slave is the scheduler.
interface clk_div_scheduler_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             clk_out;
    logic             period_start;
    logic             busy;
    logic [CNT_W-1:0] cur_half;

    modport master (
        output start, stop, cfg_valid, cfg_half,
        input  cfg_ready, clk_out, period_start, busy, cur_half
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_half,
        output cfg_ready, clk_out, period_start, busy, cur_half
    );
endinterface

// File: rtl/clk_div_scheduler.sv
// Programmable divided-clock scheduler with start/stop sequencing.
// Ratio changes and stops only take effect on period boundaries.
module clk_div_scheduler #(
    parameter int CNT_W    = 4,
    parameter int DEF_HALF = 2
) (
    input logic                clk,
    input logic                rst,
    clk_div_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_n;
    logic             div_clk, div_clk_n;
    logic             ps_pulse, ps_pulse_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] half, half_n;
    logic             pend_vld, pend_vld_n;
    logic [CNT_W-1:0] pend_val, pend_val_n;

    logic             go;
    logic             accept;
    logic             phase_end;
    logic             boundary;
    logic [CNT_W-1:0] clamped;

    assign go        = bus.start && !bus.stop;
    assign accept    = bus.cfg_valid && !pend_vld;
    assign phase_end = (cnt == half);
    assign boundary  = phase_end && !div_clk;
    assign clamped   = (bus.cfg_half == '0) ? ONE : bus.cfg_half;

    assign bus.clk_out      = div_clk;
    assign bus.period_start = ps_pulse;
    assign bus.busy         = (state != IDLE);
    assign bus.cur_half     = half;
    assign bus.cfg_ready    = !pend_vld;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_clk  <= 1'b0;
            ps_pulse <= 1'b0;
            cnt      <= '0;
            half     <= DEF;
            pend_vld <= 1'b0;
            pend_val <= '0;
        end else begin
            state    <= state_n;
            div_clk  <= div_clk_n;
            ps_pulse <= ps_pulse_n;
            cnt      <= cnt_n;
            half     <= half_n;
            pend_vld <= pend_vld_n;
            pend_val <= pend_val_n;
        end
    end

    // Next-state, phase counting and cfg handshake.
    always_comb begin
        state_n    = state;
        div_clk_n  = div_clk;
        ps_pulse_n = 1'b0;
        cnt_n      = cnt;
        half_n     = half;
        pend_vld_n = pend_vld;
        pend_val_n = pend_val;

        case (state)
            IDLE: begin
                div_clk_n = 1'b0;
                if (accept) begin
                    half_n = clamped;
                end
                if (go) begin
                    state_n    = RUN;
                    div_clk_n  = 1'b1;
                    cnt_n      = ONE;
                    ps_pulse_n = 1'b1;
                end
            end
            RUN, STOPPING: begin
                if (phase_end) begin
                    div_clk_n = !div_clk;
                    cnt_n     = ONE;
                end else begin
                    cnt_n = cnt + ONE;
                end

                if (boundary && pend_vld) begin
                    half_n     = pend_val;
                    pend_vld_n = 1'b0;
                end

                if (accept) begin
                    pend_vld_n = 1'b1;
                    pend_val_n = clamped;
                end

                if (state == RUN) begin
                    if (bus.stop) begin
                        state_n = STOPPING;
                    end
                    if (boundary) begin
                        ps_pulse_n = 1'b1;
                    end
                end else if (boundary) begin
                    // A start landing on the last low cycle
                    // still gets a fresh period issued.
                    if (go) begin
                        state_n    = RUN;
                        ps_pulse_n = 1'b1;
                    end else begin
                        state_n   = IDLE;
                        div_clk_n = 1'b0;
                    end
                end else if (go) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n    = IDLE;
                div_clk_n  = 1'b0;
                cnt_n      = '0;
                pend_vld_n = 1'b0;
            end
        endcase
    end
endmodule
